// File: rtl/cpu_control_fsm_pkg.sv
// Shared control encodings for the CPU control FSM and the datapath.
// Latency: none (constants, types and pure functions only).
// Backpressure: n/a.
package cpu_control_fsm_pkg;

    // FSM state codes, also visible on the 'state' debug output.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Instruction opcodes (instruction[7:4]); 4'hB..4'hE are reserved and run as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU function select seen by the datapath.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    // Register-file write-back source select.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    // Coarse instruction class: decides the FSM path through EXEC/MEM/WB.
    typedef enum logic [3:0] {
        CLS_NOP = 4'd0,
        CLS_ALU = 4'd1,
        CLS_LDI = 4'd2,
        CLS_LD  = 4'd3,
        CLS_ST  = 4'd4,
        CLS_JMP = 4'd5,
        CLS_BEQ = 4'd6,
        CLS_OUT = 4'd7,
        CLS_HLT = 4'd8
    } op_class_e;

    // ALU opcodes are laid out contiguously from ADD, so the select is an offset.
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [3:0] diff;
        diff = op - OP_ADD;
        return diff[2:0];
    endfunction

endpackage

// File: rtl/cpu_control_fsm_op_decode.sv
// Opcode decoder: maps a 4-bit opcode to instruction class, ALU select and write-back source.
// Latency: purely combinational.
// Backpressure: n/a. HLT decodes to CLS_HLT only when CPU_CTRL_HALT_EN is defined, else to NOP.
import cpu_control_fsm_pkg::*;

module cpu_op_decode (
    input  logic [3:0] opcode,
    output op_class_e  op_class,
    output logic [2:0] alu_op,
    output logic [1:0] wb_sel
);

    // Table lookup; anything not listed (including reserved B..E) is a NOP.
    always_comb begin
        op_class = CLS_NOP;
        alu_op   = ALU_ADD;
        wb_sel   = WB_ALU;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                op_class = CLS_ALU;
                alu_op   = alu_op_of(opcode);
                wb_sel   = WB_ALU;
            end
            OP_LDI: begin
                op_class = CLS_LDI;
                wb_sel   = WB_IMM;
            end
            OP_LD: begin
                op_class = CLS_LD;
                wb_sel   = WB_MEM;
            end
            OP_ST:  op_class = CLS_ST;
            OP_JMP: op_class = CLS_JMP;
            OP_BEQ: op_class = CLS_BEQ;
            OP_OUT: op_class = CLS_OUT;
            OP_HLT: begin
`ifdef CPU_CTRL_HALT_EN
                op_class = CLS_HLT;
`else
                op_class = CLS_NOP;
`endif
            end
            default: op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with retired-instruction counter.
// Latency: NOP 2, ST/JMP/BEQ/OUT 3, ALU/LDI/LD 4 cycles; MEM stalls until mem_ack is sampled.
// Backpressure: mem_req held until mem_ack. Optional HLT support via CPU_CTRL_HALT_EN.
import cpu_control_fsm_pkg::*;

module cpu_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_we,
    output logic [2:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       led_we,
    output logic [2:0] state,
    output logic       halted,
    output logic [7:0] retired
);

    state_e     state_q;
    logic [3:0] op_q;
    logic [7:0] retired_q;

    logic [3:0] dec_op;
    op_class_e  dec_cls;
    logic [2:0] dec_alu;
    logic [1:0] dec_wb;

    // In DECODE the live IR opcode steers the branch; afterwards the latched copy
    // is used, so the datapath is free to change opcode once DECODE is over.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

    cpu_op_decode u_decode (
        .opcode   (dec_op),
        .op_class (dec_cls),
        .alu_op   (dec_alu),
        .wb_sel   (dec_wb)
    );

    // State sequencing, opcode latch and retired counter (bumped on every return to FETCH).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_NOP;
            retired_q <= 8'd0;
        end else begin
            case (state_q)
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= opcode;
                    case (dec_cls)
                        CLS_LD, CLS_ST: state_q <= ST_MEM;
                        CLS_ALU, CLS_LDI, CLS_JMP, CLS_BEQ, CLS_OUT: state_q <= ST_EXEC;
`ifdef CPU_CTRL_HALT_EN
                        CLS_HLT: begin
                            state_q   <= ST_HALT;
                            retired_q <= retired_q + 8'd1;
                        end
`endif
                        default: begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + 8'd1;
                        end
                    endcase
                end
                ST_EXEC: begin
                    if (dec_cls == CLS_ALU || dec_cls == CLS_LDI) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q   <= ST_FETCH;
                        retired_q <= retired_q + 8'd1;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (dec_cls == CLS_LD) begin
                            state_q <= ST_WB;
                        end else begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + 8'd1;
                        end
                    end
                end
                ST_WB: begin
                    state_q   <= ST_FETCH;
                    retired_q <= retired_q + 8'd1;
                end
                ST_HALT: begin
`ifdef CPU_CTRL_HALT_EN
                    state_q <= ST_HALT;
`else
                    state_q <= ST_FETCH;
`endif
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Moore control strobes from state and latched opcode; forced low while reset is high
    // so the FETCH-state strobes do not leak out during reset.
    always_comb begin
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        reg_we  = 1'b0;
        alu_op  = ALU_ADD;
        wb_sel  = WB_ALU;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        led_we  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                ST_EXEC: begin
                    // JMP always loads; BEQ loads only on zero. pc_inc is never raised here.
                    pc_load = (dec_cls == CLS_JMP) || ((dec_cls == CLS_BEQ) && zero_flag);
                    led_we  = (dec_cls == CLS_OUT);
                    if (dec_cls == CLS_ALU) begin
                        alu_op = dec_alu;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (dec_cls == CLS_ST);
                end
                ST_WB: begin
                    // ALU select stays stable through WB so the ALU result being written is valid.
                    reg_we = 1'b1;
                    wb_sel = dec_wb;
                    if (dec_cls == CLS_ALU) begin
                        alu_op = dec_alu;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

`ifdef CPU_CTRL_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: per-instruction expected cycle traces.
// Latency: n/a (testbench).
// Backpressure: mem_ack driven by the bench with a chosen delay per LD/ST.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ack;
    logic       ir_load, pc_inc, pc_load, reg_we;
    logic [2:0] alu_op;
    logic [1:0] wb_sel;
    logic       mem_req, mem_we, led_we;
    logic [2:0] state;
    logic       halted;
    logic [7:0] retired;

    cpu_control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .mem_ack   (mem_ack),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .reg_we    (reg_we),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .led_we    (led_we),
        .state     (state),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       reg_we;
        logic [2:0] alu_op;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_we;
        logic       led_we;
        logic       halted;
        logic [7:0] retired;
    } obs_t;

    obs_t       exp_q[$];
    int         ack_at;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] ret_m;

    function automatic obs_t rec(input logic [2:0] st, input logic [7:0] r);
        obs_t o;
        o         = '0;
        o.st      = st;
        o.retired = r;
        return o;
    endfunction

    // Expected per-cycle trace of one instruction, written from the instruction's
    // cycle-by-cycle description: FETCH, DECODE, then its EXEC/MEM/WB steps.
    task automatic build(input logic [3:0] op, input logic zf, input int d);
        obs_t       o;
        logic [3:0] am;
        exp_q.delete();
        ack_at = -1;
        am = op - 4'd1;
        o = rec(3'd0, ret_m); o.ir_load = 1'b1; o.pc_inc = 1'b1; exp_q.push_back(o);
        exp_q.push_back(rec(3'd1, ret_m));
        if (op >= 4'd1 && op <= 4'd4) begin
            o = rec(3'd2, ret_m); o.alu_op = am[2:0]; exp_q.push_back(o);
            o = rec(3'd4, ret_m); o.alu_op = am[2:0]; o.reg_we = 1'b1; o.wb_sel = 2'd0; exp_q.push_back(o);
        end else if (op == 4'd5) begin
            exp_q.push_back(rec(3'd2, ret_m));
            o = rec(3'd4, ret_m); o.reg_we = 1'b1; o.wb_sel = 2'd1; exp_q.push_back(o);
        end else if (op == 4'd6 || op == 4'd7) begin
            for (int k = 0; k <= d; k++) begin
                o = rec(3'd3, ret_m); o.mem_req = 1'b1; o.mem_we = (op == 4'd7); exp_q.push_back(o);
            end
            ack_at = exp_q.size() - 1;
            if (op == 4'd6) begin
                o = rec(3'd4, ret_m); o.reg_we = 1'b1; o.wb_sel = 2'd2; exp_q.push_back(o);
            end
        end else if (op == 4'd8) begin
            o = rec(3'd2, ret_m); o.pc_load = 1'b1; exp_q.push_back(o);
        end else if (op == 4'd9) begin
            o = rec(3'd2, ret_m); o.pc_load = zf; exp_q.push_back(o);
        end else if (op == 4'hA) begin
            o = rec(3'd2, ret_m); o.led_we = 1'b1; exp_q.push_back(o);
        end
`ifdef CPU_CTRL_HALT_EN
        else if (op == 4'hF) begin
            for (int k = 0; k < 20; k++) begin
                o = rec(3'd5, ret_m + 8'd1); o.halted = 1'b1; exp_q.push_back(o);
            end
        end
`endif
    endtask

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = {state, ir_load, pc_inc, pc_load, reg_we, alu_op, wb_sel,
             mem_req, mem_we, led_we, halted, retired};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s act=%h exp=%h", name, a, e);
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s act=%0d exp=%0d", name, act, expv);
    endtask

    // Run one instruction (optionally only its first 'limit' cycles), checking every cycle.
    task automatic run(input logic [3:0] op, input logic zf, input int d, input int limit);
        int n;
        build(op, zf, d);
        zero_flag = zf;
        n = exp_q.size();
        for (int i = 0; i < n && i < limit; i++) begin
            @(negedge clk);
            check($sformatf("op%h_zf%0d_d%0d_cyc%0d", op, zf, d, i), exp_q[i]);
            if (i <= 1) opcode = op;
            else        opcode = 4'($urandom);
            if (exp_q[i].st == 3'd3) mem_ack = (i == ack_at);
            else                     mem_ack = 1'($urandom);
        end
        if (limit >= n) ret_m = ret_m + 8'd1;
    endtask

    // Look at retired just after the edge that returns to FETCH.
    task automatic peek_retired(input string name, input logic [7:0] expv);
        @(posedge clk);
        #1;
        check_int(name, int'(retired), int'(expv));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check(name, rec(3'd0, 8'd0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ack = 1'b0;
        ret_m   = 8'd0;
    endtask

    initial begin
        logic [3:0] rop;
        reset     = 1'b1;
        opcode    = 4'd0;
        zero_flag = 1'b0;
        mem_ack   = 1'b0;
        ret_m     = 8'd0;

        // Pin the model against hand-derived cycle counts and strobes.
        build(4'h1, 1'b0, 0);
        check_int("model_add_len", exp_q.size(), 4);
        check_int("model_add_wb_state", int'(exp_q[3].st), 4);
        build(4'h6, 1'b0, 3);
        check_int("model_ld_d3_len", exp_q.size(), 7);
        build(4'h7, 1'b0, 0);
        check_int("model_st_len", exp_q.size(), 3);
        build(4'h0, 1'b0, 0);
        check_int("model_nop_len", exp_q.size(), 2);
        build(4'h9, 1'b1, 0);
        check_int("model_beq_taken_pcload", int'(exp_q[2].pc_load), 1);

        #200;
        check("reset_hold", rec(3'd0, 8'd0));
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_int("first_fetch_ir_load", int'(ir_load), 1);

        run(4'h1, 1'b0, 0, 99);
        peek_retired("retired_after_add", 8'd1);
        run(4'h6, 1'b0, 3, 99);
        peek_retired("retired_after_ld", 8'd2);
        run(4'h9, 1'b1, 0, 99);
        run(4'h9, 1'b0, 0, 99);
        run(4'h7, 1'b0, 0, 99);
        run(4'h7, 1'b1, 2, 99);
        run(4'h8, 1'b0, 0, 99);
        run(4'hA, 1'b0, 0, 99);
        run(4'h5, 1'b0, 0, 99);
        run(4'h2, 1'b1, 0, 99);
        run(4'h3, 1'b0, 0, 99);
        run(4'h4, 1'b0, 0, 99);
        for (int k = 11; k <= 14; k++) run(4'(k), 1'b0, 0, 99);

        // Abandon an LD while it waits for mem_ack.
        run(4'h6, 1'b0, 5, 4);
        do_reset("reset_in_mem");
        run(4'h1, 1'b0, 0, 99);

        for (int k = 0; k < 120; k++) begin
`ifdef CPU_CTRL_HALT_EN
            rop = 4'($urandom_range(0, 14));
`else
            rop = 4'($urandom_range(0, 15));
`endif
            run(rop, 1'($urandom), int'($urandom_range(0, 3)), 99);
        end

        do_reset("reset_before_wrap");
        for (int k = 0; k < 255; k++) run(4'h0, 1'b0, 0, 99);
        peek_retired("retired_ff", 8'hFF);
        run(4'h0, 1'b0, 0, 99);
        peek_retired("retired_wrap_00", 8'h00);

        run(4'hF, 1'b0, 0, 99);
`ifdef CPU_CTRL_HALT_EN
        check_int("halt_still_halted", int'(halted), 1);
`else
        run(4'h1, 1'b0, 0, 99);
        check_int("hlt_as_nop_halted", int'(halted), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
